dispatch_ctrl: RTL

- Sequences the in-order dispatch stage between the instruction fetch queue (IFQ) and the three issue queues: integer, load/store and multiply.
- Takes the combinational decoder outputs for the instruction at the IFQ head and decides, cycle by cycle, whether to pop it.
- Presents a registered, one-cycle write pulse to the target queue and allocates ROB tags in order.
- Handles stalls, jumps, illegal opcodes and CDB-driven flushes.

---
 rtl/dispatch_ctrl_if.sv | 68 ++++++
 rtl/dispatch_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dispatch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_ctrl_if
// Description : Bundles the IFQ, decoder, issue-queue, ROB and CDB signals
//               that connect to the dispatch controller.
//               master : the dispatch controller (drives Dispatch_* signals)
//               slave  : the surrounding pipeline (drives everything else)
// Ports       : none (clock and reset are plain ports on the controller)
// Revision    : 1.0 - initial release
// ============================================================================
interface dispatch_ctrl_if #(
  parameter int TAG_WIDTH = 5
);
  // IFQ head and decoder
  logic                 Ifq_Empty;
  logic [31:0]          Ifq_Inst;
  logic [31:0]          Ifq_Pc;
  logic [3:0]           Dec_Opcode;
  logic [31:0]          Dec_Imm;
  logic                 Dec_en_Int;
  logic                 Dec_en_LS;
  logic                 Dec_en_Mult;
  logic                 Dec_Type_J;
  logic                 Dec_Branch;
  // back-pressure
  logic                 Int_Full;
  logic                 LS_Full;
  logic                 Mult_Full;
  logic                 Rob_Full;
  // common data bus
  logic                 Cdb_Flush;
  logic [TAG_WIDTH-1:0] Cdb_Flush_Tag;
  logic                 Cdb_Branch_Done;
  // dispatch outputs
  logic                 Dispatch_Ren;
  logic                 Dispatch_Int_Wen;
  logic                 Dispatch_LS_Wen;
  logic                 Dispatch_Mult_Wen;
  logic [3:0]           Dispatch_Opcode;
  logic [31:0]          Dispatch_Imm;
  logic                 Dispatch_Branch;
  logic [TAG_WIDTH-1:0] Dispatch_Tag;
  logic                 Dispatch_Jmp;
  logic [31:0]          Dispatch_Jmp_Addr;
  logic                 Dispatch_Illegal;
  logic                 Dispatch_Stall;

  modport master (
    input  Ifq_Empty, Ifq_Inst, Ifq_Pc, Dec_Opcode, Dec_Imm,
           Dec_en_Int, Dec_en_LS, Dec_en_Mult, Dec_Type_J, Dec_Branch,
           Int_Full, LS_Full, Mult_Full, Rob_Full,
           Cdb_Flush, Cdb_Flush_Tag, Cdb_Branch_Done,
    output Dispatch_Ren, Dispatch_Int_Wen, Dispatch_LS_Wen, Dispatch_Mult_Wen,
           Dispatch_Opcode, Dispatch_Imm, Dispatch_Branch, Dispatch_Tag,
           Dispatch_Jmp, Dispatch_Jmp_Addr, Dispatch_Illegal, Dispatch_Stall
  );

  modport slave (
    output Ifq_Empty, Ifq_Inst, Ifq_Pc, Dec_Opcode, Dec_Imm,
           Dec_en_Int, Dec_en_LS, Dec_en_Mult, Dec_Type_J, Dec_Branch,
           Int_Full, LS_Full, Mult_Full, Rob_Full,
           Cdb_Flush, Cdb_Flush_Tag, Cdb_Branch_Done,
    input  Dispatch_Ren, Dispatch_Int_Wen, Dispatch_LS_Wen, Dispatch_Mult_Wen,
           Dispatch_Opcode, Dispatch_Imm, Dispatch_Branch, Dispatch_Tag,
           Dispatch_Jmp, Dispatch_Jmp_Addr, Dispatch_Illegal, Dispatch_Stall
  );
endinterface
`default_nettype wire

// File: rtl/dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_ctrl
// Description : In-order dispatch sequencer between the IFQ and the integer,
//               load/store and multiply issue queues. Pops the IFQ head
//               combinationally, issues a registered one-cycle write pulse to
//               the target queue and allocates ROB tags in order. Handles
//               stalls, jumps, illegal words and CDB flushes.
// Ports       : Clk    - rising-edge clock
//               Resetb - synchronous active-low reset
//               bus    - dispatch_ctrl_if.master (IFQ/decoder/queue/CDB in,
//                        Dispatch_* out)
// Options     : DISPATCH_BRANCH_LIMIT_EN - allow only one unresolved branch
//               in flight; later branches stall until Cdb_Branch_Done.
// Revision    : 1.0 - initial release
// ============================================================================
module dispatch_ctrl #(
  parameter int TAG_WIDTH    = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  wire logic           Clk,
  input  wire logic           Resetb,
  dispatch_ctrl_if.master     bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t               r_state, w_next_state;
  logic [2:0]           r_flush_cnt, w_next_flush_cnt;
  logic [TAG_WIDTH-1:0] r_tag;

  logic w_head_valid, w_is_jump, w_is_illegal, w_target_full;
  logic w_branch_block, w_blocked, w_accept, w_dispatch;

`ifdef DISPATCH_BRANCH_LIMIT_EN
  logic r_branch_pending;
  // A resolving branch frees the slot in the same cycle, so a waiting
  // branch can go out alongside Cdb_Branch_Done.
  assign w_branch_block = r_branch_pending && bus.Dec_Branch && !bus.Cdb_Branch_Done;

  always_ff @(posedge Clk) begin
    if (!Resetb || bus.Cdb_Flush)
      r_branch_pending <= 1'b0;
    else if (w_dispatch && bus.Dec_Branch)
      r_branch_pending <= 1'b1;   // new branch wins over a same-cycle clear
    else if (bus.Cdb_Branch_Done)
      r_branch_pending <= 1'b0;
  end
`else
  assign w_branch_block = 1'b0;
  logic w_unused_branch_done;
  assign w_unused_branch_done = bus.Cdb_Branch_Done;
`endif

  // Only the jump-target fields of the instruction and PC are consumed here.
  logic w_unused_fields;
  assign w_unused_fields = &{1'b0, bus.Ifq_Inst[31:26], bus.Ifq_Pc[27:0]};

  assign w_head_valid  = !bus.Ifq_Empty;
  assign w_is_jump     = bus.Dec_Type_J;
  assign w_is_illegal  = !bus.Dec_Type_J &&
                         !(bus.Dec_en_Int || bus.Dec_en_LS || bus.Dec_en_Mult);
  assign w_target_full = (bus.Dec_en_Int  && bus.Int_Full) ||
                         (bus.Dec_en_LS   && bus.LS_Full)  ||
                         (bus.Dec_en_Mult && bus.Mult_Full);
  assign w_blocked     = w_target_full || bus.Rob_Full || w_branch_block;

  // Jumps and illegal words take no queue slot and no tag, so nothing can
  // block them.
  assign w_accept = Resetb && !bus.Cdb_Flush && (r_state != FLUSH) &&
                    w_head_valid && (w_is_jump || w_is_illegal || !w_blocked);
  assign w_dispatch = w_accept && !w_is_jump && !w_is_illegal;

  assign bus.Dispatch_Ren = w_accept;

  always_ff @(posedge Clk) begin
    if (!Resetb) begin
      r_state     <= RUN;
      r_flush_cnt <= 3'd0;
    end else begin
      r_state     <= w_next_state;
      r_flush_cnt <= w_next_flush_cnt;
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_next_flush_cnt = r_flush_cnt;
    if (bus.Cdb_Flush) begin
      w_next_state     = FLUSH;
      w_next_flush_cnt = FLUSH_LOAD;
    end else begin
      case (r_state)
        FLUSH: begin
          if (r_flush_cnt <= 3'd1) begin
            w_next_state     = RUN;
            w_next_flush_cnt = 3'd0;
          end else begin
            w_next_flush_cnt = r_flush_cnt - 3'd1;
          end
        end
        default: begin
          w_next_state = RUN;
          if (w_head_valid) begin
            if (w_is_jump) begin
              w_next_state     = FLUSH;
              w_next_flush_cnt = FLUSH_LOAD;
            end else if (!w_is_illegal && w_blocked) begin
              w_next_state = STALL;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Resetb) begin
      r_tag                 <= '0;
      bus.Dispatch_Int_Wen  <= 1'b0;
      bus.Dispatch_LS_Wen   <= 1'b0;
      bus.Dispatch_Mult_Wen <= 1'b0;
      bus.Dispatch_Opcode   <= 4'd0;
      bus.Dispatch_Imm      <= 32'd0;
      bus.Dispatch_Branch   <= 1'b0;
      bus.Dispatch_Tag      <= '0;
      bus.Dispatch_Jmp      <= 1'b0;
      bus.Dispatch_Jmp_Addr <= 32'd0;
      bus.Dispatch_Illegal  <= 1'b0;
      bus.Dispatch_Stall    <= 1'b0;
    end else begin
      bus.Dispatch_Int_Wen  <= w_dispatch && bus.Dec_en_Int;
      bus.Dispatch_LS_Wen   <= w_dispatch && bus.Dec_en_LS;
      bus.Dispatch_Mult_Wen <= w_dispatch && bus.Dec_en_Mult;
      bus.Dispatch_Branch   <= w_dispatch && bus.Dec_en_Int && bus.Dec_Branch;
      bus.Dispatch_Jmp      <= w_accept && w_is_jump;
      bus.Dispatch_Illegal  <= w_accept && w_is_illegal;
      bus.Dispatch_Stall    <= (w_next_state == STALL);
      if (w_dispatch) begin
        bus.Dispatch_Opcode <= bus.Dec_Opcode;
        bus.Dispatch_Imm    <= bus.Dec_Imm;
        bus.Dispatch_Tag    <= r_tag;
      end
      if (w_accept && w_is_jump)
        bus.Dispatch_Jmp_Addr <= {bus.Ifq_Pc[31:28], bus.Ifq_Inst[25:0], 2'b00};
      // Younger tags are discarded on a flush; allocation resumes just past
      // the mispredicted branch.
      if (bus.Cdb_Flush)
        r_tag <= bus.Cdb_Flush_Tag + TAG_WIDTH'(1);
      else if (w_dispatch)
        r_tag <= r_tag + TAG_WIDTH'(1);
    end
  end

endmodule
`default_nettype wire
